terminal_port_arbiter: RTL and testbench
========================================

// Module: terminal_port_arbiter
// PURPOSE
//  Shares the single text port of Terminal (12b addr, 8b data) between two requesters:
//  req0 = debugger overlay writer, req1 = CPU memory-mapped console.
//  Adds a built-in clear engine that fills the text buffer with FILL_CHAR on command.
//  Sits between debugger/CPU console and Terminal in the top level. Runs on the 25 MHz domain.
// PARAMETERS
//  TEXT_DEPTH  2400   number of character cells cleared (80x30); max 4096
//  FILL_CHAR   8'h20  byte written by the clear engine (space)
// PORTS
//  clock            in   1   system clock (25 MHz domain)
//  reset            in   1   asynchronous, active-high
//  req              in   2   per-requester access request, level, held until granted
//  we               in   2   per-requester write enable (1=write, 0=read)
//  addr0, addr1     in   12  per-requester text address
//  wdata0, wdata1   in   8   per-requester write data
//  gnt              out  2   one-hot grant; access completes in the cycle gnt[i]=1
//  rvalid           out  2   pulse one cycle after a granted read
//  rdata            out  8   read data, valid while rvalid!=0
//  clear_start      in   1   pulse: start clearing the whole buffer
//  clear_busy       out  1   high while the clear engine owns the port
//  clear_done       out  1   one-cycle pulse after the last clear write
//  textAddress      out  12  to Terminal
//  shouldWriteText  out  1   to Terminal
//  textWriteData    out  8   to Terminal
//  textReadData     in   8   from Terminal; valid one cycle after textAddress
// BEHAVIOUR
//  - Reset values: gnt=0, rvalid=0, rdata=0, clear_busy=0, clear_done=0, textAddress=0,
//    shouldWriteText=0, textWriteData=0; state=IDLE, last=1 (req0 wins first tie), cnt=0.
//  - FSM states: IDLE, CLEAR.
//  - IDLE: gnt is combinational from req and last:
//      one req -> grant it; both -> grant ~last; none -> gnt=0.
//    The granted requester's addr/wdata/we drive the text port in the same cycle.
//    shouldWriteText = we[i] & gnt[i]. last updates to i at the clock edge.
//  - Throughput: one access per cycle. A requester holding req gets gnt at most every other
//    cycle under contention. No starvation.
//  - Reads: rvalid[i] is registered, high the cycle after the granted read.
//    rdata = textReadData in that cycle. A back-to-back read the next cycle is allowed.
//  - clear_start sampled high in IDLE -> CLEAR on the next edge; cnt=0.
//    A request granted in the same cycle as clear_start still completes.
//  - CLEAR: gnt=0, clear_busy=1, textAddress=cnt, shouldWriteText=1, textWriteData=FILL_CHAR.
//    cnt increments each cycle. After writing cnt==TEXT_DEPTH-1 -> IDLE,
//    clear_done=1 for one cycle, cnt=0.
//    A clear takes exactly TEXT_DEPTH cycles.
//  - clear_start during CLEAR is ignored (no restart, no queue).
//  - Pending req during CLEAR is held off. It is served on the first IDLE cycle after CLEAR.
//  - Reset mid-clear aborts immediately: no done pulse, buffer partially cleared.
//  - Idle port (no grant, not clearing): shouldWriteText=0, textAddress holds its last value.
//  - Address arithmetic: cnt is 12b unsigned and never wraps (terminates at TEXT_DEPTH-1).
// STRUCTURE
//  - Shared package (terminal_pkg): TEXT_ADDR_W=12, TEXT_DATA_W=8, TEXT_COLS=80,
//    TEXT_ROWS=30, FSM state encoding.
//  - Single module. The round-robin 2-way picker is a natural sub-module: rr_arbiter2
//    (req[1:0], last -> gnt[1:0]).
// TESTING
//  1. req=2'b01, we0=1, addr0=12'h005, wdata0=8'h41
//     -> gnt=01 same cycle, textAddress=005, shouldWriteText=1, textWriteData=41.
//  2. req=2'b11 held 4 cycles, both writes
//     -> gnt sequence 01,10,01,10; shouldWriteText=1 every cycle.
//  3. req1 read addr1=12'h123, Terminal returns 8'h5A
//     -> rvalid=10 next cycle, rdata=5A; rvalid=0 after.
//  4. clear_start pulse, TEXT_DEPTH=2400
//     -> clear_busy high 2400 cycles; writes of 20 at 0..2399; clear_done one cycle after; gnt=0 throughout.
//  5. req0 raised at clear cycle 10 and held
//     -> gnt0 asserted on the first IDLE cycle after clear_done; second clear_start mid-clear has no effect.
//  6. reset asserted at clear cycle 100
//     -> all outputs to reset values asynchronously; no clear_done; next clear_start restarts at address 0.

Source files
------------

// File: rtl/terminal_pkg.sv
// Shared text-port geometry and arbiter FSM encoding for the Terminal block.
package terminal_pkg;

  localparam int unsigned TEXT_ADDR_W = 12;
  localparam int unsigned TEXT_DATA_W = 8;
  localparam int unsigned TEXT_COLS   = 80;
  localparam int unsigned TEXT_ROWS   = 30;

  typedef enum logic {
    StIdle,
    StClear
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: on a tie the requester that was not served last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/terminal_port_arbiter.sv
// Shares the Terminal text port between the debugger overlay and the CPU console,
// with a built-in engine that fills the whole buffer with FILL_CHAR.
module terminal_port_arbiter
  import terminal_pkg::*;
#(
  parameter int unsigned                   TEXT_DEPTH = 2400,
  parameter logic [TEXT_DATA_W-1:0]        FILL_CHAR  = 8'h20
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [1:0]             req,
  input  logic [1:0]             we,
  input  logic [TEXT_ADDR_W-1:0] addr0,
  input  logic [TEXT_ADDR_W-1:0] addr1,
  input  logic [TEXT_DATA_W-1:0] wdata0,
  input  logic [TEXT_DATA_W-1:0] wdata1,
  output logic [1:0]             gnt,
  output logic [1:0]             rvalid,
  output logic [TEXT_DATA_W-1:0] rdata,
  input  logic                   clear_start,
  output logic                   clear_busy,
  output logic                   clear_done,
  output logic [TEXT_ADDR_W-1:0] textAddress,
  output logic                   shouldWriteText,
  output logic [TEXT_DATA_W-1:0] textWriteData,
  input  logic [TEXT_DATA_W-1:0] textReadData
);

  localparam logic [TEXT_ADDR_W-1:0] LastAddr = TEXT_ADDR_W'(TEXT_DEPTH - 1);

  arb_state_e             state_q, state_d;
  logic                   last_q, last_d;
  logic [TEXT_ADDR_W-1:0] cnt_q, cnt_d;
  logic [TEXT_ADDR_W-1:0] addr_q;
  logic [TEXT_DATA_W-1:0] wdata_q;
  logic [1:0]             rvalid_q;
  logic                   done_q, done_d;
  logic [1:0]             arb_gnt;

  rr_arbiter2 u_rr_arbiter2 (
    .req  (req),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    cnt_d           = cnt_q;
    done_d          = 1'b0;
    gnt             = 2'b00;
    clear_busy      = 1'b0;
    shouldWriteText = 1'b0;
    // With nothing driving the port, address and data hold their last value.
    textAddress     = addr_q;
    textWriteData   = wdata_q;

    unique case (state_q)
      StIdle: begin
        gnt = arb_gnt;
        if (gnt[0]) begin
          textAddress     = addr0;
          textWriteData   = wdata0;
          shouldWriteText = we[0];
          last_d          = 1'b0;
        end else if (gnt[1]) begin
          textAddress     = addr1;
          textWriteData   = wdata1;
          shouldWriteText = we[1];
          last_d          = 1'b1;
        end
        if (clear_start) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        clear_busy      = 1'b1;
        textAddress     = cnt_q;
        textWriteData   = FILL_CHAR;
        shouldWriteText = 1'b1;
        if (cnt_q == LastAddr) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= 2'b00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      addr_q   <= textAddress;
      wdata_q  <= textWriteData;
      rvalid_q <= gnt & ~we;
      done_q   <= done_d;
    end
  end

  assign rvalid     = rvalid_q;
  assign rdata      = (|rvalid_q) ? textReadData : '0;
  assign clear_done = done_q;

endmodule

// File: tb/tb_terminal_port_arbiter.sv
// Directed bench for terminal_port_arbiter: arbitration, reads, clear engine, reset abort.
module tb_terminal_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req, we, gnt, rvalid;
  logic [11:0] addr0, addr1, textAddress;
  logic [7:0]  wdata0, wdata1, rdata, textWriteData, textReadData;
  logic        clear_start, clear_busy, clear_done, shouldWriteText;

  int checks = 0;
  int errors = 0;

  terminal_port_arbiter dut (
    .clock           (clock),
    .reset           (reset),
    .req             (req),
    .we              (we),
    .addr0           (addr0),
    .addr1           (addr1),
    .wdata0          (wdata0),
    .wdata1          (wdata1),
    .gnt             (gnt),
    .rvalid          (rvalid),
    .rdata           (rdata),
    .clear_start     (clear_start),
    .clear_busy      (clear_busy),
    .clear_done      (clear_done),
    .textAddress     (textAddress),
    .shouldWriteText (shouldWriteText),
    .textWriteData   (textWriteData),
    .textReadData    (textReadData)
  );

  always #5 clock = ~clock;

  // Terminal stand-in: one-cycle read latency, 0x5A at address 0x123.
  always @(posedge clock) textReadData <= (textAddress == 12'h123) ? 8'h5A : 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_gnt"}, 32'(gnt), 0);
    check_eq({tag, "_rvalid"}, 32'(rvalid), 0);
    check_eq({tag, "_rdata"}, 32'(rdata), 0);
    check_eq({tag, "_busy"}, 32'(clear_busy), 0);
    check_eq({tag, "_done"}, 32'(clear_done), 0);
    check_eq({tag, "_addr"}, 32'(textAddress), 0);
    check_eq({tag, "_we"}, 32'(shouldWriteText), 0);
    check_eq({tag, "_wdata"}, 32'(textWriteData), 0);
  endtask

  initial begin
    int bad;
    reset = 1'b1; req = 2'b00; we = 2'b00; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; clear_start = 1'b0;
    #2;
    check_reset_outputs("reset");
    tick();
    reset = 1'b0;

    // 1: single write from requester 0
    req = 2'b01; we = 2'b01; addr0 = 12'h005; wdata0 = 8'h41;
    @(negedge clock);
    check_eq("t1_gnt", 32'(gnt), 32'h1);
    check_eq("t1_addr", 32'(textAddress), 32'h005);
    check_eq("t1_we", 32'(shouldWriteText), 1);
    check_eq("t1_wdata", 32'(textWriteData), 32'h41);
    tick();
    req = 2'b00;

    // Reset again so last=1 and the contention sequence starts with requester 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // 2: both requesters writing, alternating grants
    req = 2'b11; we = 2'b11;
    addr0 = 12'h010; wdata0 = 8'hA0; addr1 = 12'h020; wdata1 = 8'hB0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check_eq($sformatf("t2_gnt%0d", k), 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
      check_eq($sformatf("t2_we%0d", k), 32'(shouldWriteText), 1);
      check_eq($sformatf("t2_addr%0d", k), 32'(textAddress),
               (k % 2 == 0) ? 32'h010 : 32'h020);
      tick();
    end
    req = 2'b00;
    @(negedge clock);
    check_eq("idle_gnt", 32'(gnt), 0);
    check_eq("idle_we", 32'(shouldWriteText), 0);
    check_eq("idle_addr_hold", 32'(textAddress), 32'h020);
    tick();

    // 3: requester 1 read
    req = 2'b10; we = 2'b00; addr1 = 12'h123;
    @(negedge clock);
    check_eq("t3_gnt", 32'(gnt), 32'h2);
    check_eq("t3_we", 32'(shouldWriteText), 0);
    check_eq("t3_rvalid_early", 32'(rvalid), 0);
    tick();
    req = 2'b00;
    @(negedge clock);
    check_eq("t3_rvalid", 32'(rvalid), 32'h2);
    check_eq("t3_rdata", 32'(rdata), 32'h5A);
    tick();
    @(negedge clock);
    check_eq("t3_rvalid_after", 32'(rvalid), 0);
    tick();

    // 4/5: full clear, req0 raised at clear cycle 10, second start at cycle 50
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    bad = 0;
    for (int i = 0; i < 2400; i++) begin
      if (i == 10) begin
        req = 2'b01; we = 2'b01; addr0 = 12'h007; wdata0 = 8'h33;
      end
      clear_start = (i == 50);
      @(negedge clock);
      if (gnt !== 2'b00 || clear_busy !== 1'b1 || shouldWriteText !== 1'b1 ||
          textAddress !== 12'(i) || textWriteData !== 8'h20 || clear_done !== 1'b0)
        bad++;
      if (i == 0) check_eq("clr_first_addr", 32'(textAddress), 0);
      if (i == 2399) check_eq("clr_last_addr", 32'(textAddress), 2399);
      tick();
    end
    clear_start = 1'b0;
    check_eq("clr_walk_bad_cycles", 32'(bad), 0);
    @(negedge clock);
    check_eq("clr_done", 32'(clear_done), 1);
    check_eq("clr_busy_off", 32'(clear_busy), 0);
    check_eq("t5_gnt_after", 32'(gnt), 32'h1);
    check_eq("t5_addr_after", 32'(textAddress), 32'h007);
    check_eq("t5_wdata_after", 32'(textWriteData), 32'h33);
    tick();
    req = 2'b00;
    @(negedge clock);
    check_eq("clr_done_pulse", 32'(clear_done), 0);
    check_eq("t5_no_restart", 32'(clear_busy), 0);
    tick();

    // 6: reset at clear cycle 100
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    @(negedge clock);
    check_eq("t6_mid_addr", 32'(textAddress), 100);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    tick();
    reset = 1'b0;
    @(negedge clock);
    check_eq("t6_no_done", 32'(clear_done), 0);
    check_eq("t6_idle", 32'(clear_busy), 0);
    tick();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    @(negedge clock);
    check_eq("t6_restart_busy", 32'(clear_busy), 1);
    check_eq("t6_restart_addr0", 32'(textAddress), 0);
    tick();
    @(negedge clock);
    check_eq("t6_restart_addr1", 32'(textAddress), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
